// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: single-outstanding bridge from the shared cache memory
// port to an AXI3/4 master interface. One read (AR/R) or write (AW/W/B)
// transaction is in flight at a time; completion is a one-cycle mem_ready.
// Optional build macro AXI_BRIDGE_ERR_CAPTURE_EN adds a sticky bus_err flag
// and err_addr capture of the first transaction answered with SLVERR/DECERR.
// Every AXI output is decoded from registered state only, so there is no
// combinational path from an AXI input to an AXI output.
module cache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'b0000
) (
    input  logic        clk,
    input  logic        resetn,
    // cache side
    input  logic [31:0] mem_a,
    input  logic        mem_access,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_st_data,
    output logic [31:0] mem_data,
    output logic        mem_ready,
`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
    output logic        bus_err,
    output logic [31:0] err_addr,
`endif
    // AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AW channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // W channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // B channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic [31:0] addr_lat;
    logic [1:0]  size_lat;
    logic [3:0]  sel_lat;
    logic [31:0] wdata_lat;
    logic        aw_done;
    logic        w_done;

    // Response ID/last fields carry no information for single-beat,
    // single-ID traffic; they are deliberately left unused.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rlast, rresp, bid, bresp};

    // Transaction sequencer: accept a request, run its handshakes, pulse done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_lat  <= 32'd0;
            size_lat  <= 2'd0;
            sel_lat   <= 4'd0;
            wdata_lat <= 32'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            mem_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_access) begin
                        addr_lat  <= mem_a;
                        size_lat  <= mem_size;
                        sel_lat   <= mem_sel;
                        wdata_lat <= mem_st_data;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= mem_write ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid) begin
                        mem_data <= rdata;
                        state    <= DONE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in either order
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                    if ((aw_done || awready) && (w_done || wready)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (bvalid) state <= DONE;
                end
                DONE: begin
                    // mem_access is not sampled here, giving the cache one
                    // edge to withdraw the request
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
    // Sticky error flag with the address of the first failing transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err  <= 1'b0;
            err_addr <= 32'd0;
        end else if (!bus_err &&
                     (((state == RD_DATA) && rvalid && rresp[1]) ||
                      ((state == WR_RESP) && bvalid && bresp[1]))) begin
            bus_err  <= 1'b1;
            err_addr <= addr_lat;
        end
    end
`endif

    assign mem_ready = (state == DONE);

    assign arid    = AXI_ID;
    assign araddr  = addr_lat;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_lat};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = addr_lat;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_lat};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (state == WR_REQ) && !aw_done;

    assign wid     = AXI_ID;
    assign wdata   = wdata_lat;
    assign wstrb   = sel_lat;
    assign wlast   = 1'b1;
    assign wvalid  = (state == WR_REQ) && !w_done;

    assign bready  = (state == WR_RESP);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scoreboard bench for cache_axi_bridge. A cycle-level AXI slave with
// per-channel programmable wait states answers the DUT; the driver pushes the
// expected AXI requests and completion data into queues; a monitor pops and
// compares on every handshake and every mem_ready pulse.
// Build with +define+AXI_BRIDGE_ERR_CAPTURE_EN to exercise error capture.
`timescale 1ns/1ps
module tb_cache_axi_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
    } addr_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic [31:0] mem_data;
    logic        mem_ready;
`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
    logic        bus_err;
    logic [31:0] err_addr;
`endif
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_data(mem_data), .mem_ready(mem_ready),
`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
        .bus_err(bus_err), .err_addr(err_addr),
`endif
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // scoreboard queues and reference state
    addr_t       q_ar[$];
    addr_t       q_aw[$];
    wbeat_t      q_w[$];
    logic [31:0] q_cmp[$];
    logic [31:0] last_rd = 32'd0;

    // slave configuration for the current transaction
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rd_val = 32'd0;
    logic [1:0]  rd_resp = 2'b00;
    logic [1:0]  wr_resp = 2'b00;
    int          ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // AXI slave: drives its ready/valid at the falling edge, holding each
    // DUT valid/ready for the programmed number of wait cycles first
    initial begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; bid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            rdata = $urandom; rresp = 2'($urandom); rid = 4'($urandom);
            rlast = 1'($urandom); bresp = 2'($urandom); bid = 4'($urandom);
            if (!resetn) begin
                ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
            end else begin
                if (arvalid) begin
                    if (ar_c >= ar_dly) begin arready = 1; ar_c = 0; end else ar_c++;
                end
                if (rready) begin
                    if (r_c >= r_dly) begin
                        rvalid = 1; rdata = rd_val; rresp = rd_resp; rlast = 1; rid = 0; r_c = 0;
                    end else r_c++;
                end
                if (awvalid) begin
                    if (aw_c >= aw_dly) begin awready = 1; aw_c = 0; end else aw_c++;
                end
                if (wvalid) begin
                    if (w_c >= w_dly) begin wready = 1; w_c = 0; end else w_c++;
                end
                if (bready) begin
                    if (b_c >= b_dly) begin bvalid = 1; bresp = wr_resp; bid = 0; b_c = 0; end else b_c++;
                end
            end
        end
    end

    // Monitor: compares every handshake and completion against the queues
    initial begin
        addr_t       e_a;
        wbeat_t      e_w;
        logic [31:0] e_d;
        logic [31:0] prev_araddr;
        logic        prev_ar_wait;
        prev_ar_wait = 0;
        prev_araddr  = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                prev_ar_wait = 0;
            end else begin
                if (arvalid && prev_ar_wait) check("araddr_stable", 64'(araddr), 64'(prev_araddr));
                prev_ar_wait = arvalid && !arready;
                prev_araddr  = araddr;
                if (arvalid && arready) begin
                    if (q_ar.size() == 0) fail_now("ar_unexpected");
                    else begin
                        e_a = q_ar.pop_front();
                        check("araddr", 64'(araddr), 64'(e_a.addr));
                        check("arsize", 64'(arsize), 64'({1'b0, e_a.size}));
                        check("ar_const", 64'({arid, arlen, arburst, arlock, arcache, arprot}),
                              64'({4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'h0}));
                    end
                end
                if (awvalid && awready) begin
                    if (q_aw.size() == 0) fail_now("aw_unexpected");
                    else begin
                        e_a = q_aw.pop_front();
                        check("awaddr", 64'(awaddr), 64'(e_a.addr));
                        check("awsize", 64'(awsize), 64'({1'b0, e_a.size}));
                        check("aw_const", 64'({awid, awlen, awburst, awlock, awcache, awprot}),
                              64'({4'h0, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0}));
                    end
                end
                if (wvalid && wready) begin
                    if (q_w.size() == 0) fail_now("w_unexpected");
                    else begin
                        e_w = q_w.pop_front();
                        check("wdata", 64'(wdata), 64'(e_w.data));
                        check("wstrb", 64'(wstrb), 64'(e_w.strb));
                        check("w_const", 64'({wid, wlast}), 64'({4'h0, 1'b1}));
                    end
                end
                if (mem_ready) begin
                    if (q_cmp.size() == 0) fail_now("mem_ready_unexpected");
                    else begin
                        e_d = q_cmp.pop_front();
                        check("mem_data", 64'(mem_data), 64'(e_d));
                    end
                end
            end
        end
    end

    // Issue one request, hold it until mem_ready, then withdraw it
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [3:0] sel, input logic [31:0] d,
                          input logic [31:0] rv, input logic [1:0] resp,
                          input int dar, input int dr, input int daw, input int dw, input int db);
        addr_t  ea;
        wbeat_t ew;
        int     cyc;
        int     exp_lat;
        ar_dly = dar; r_dly = dr; aw_dly = daw; w_dly = dw; b_dly = db;
        rd_val = rv; rd_resp = resp; wr_resp = resp;
        @(negedge clk);
        mem_access = 1; mem_write = wr; mem_a = a; mem_size = sz;
        mem_sel = sel; mem_st_data = d;
        ea.addr = a; ea.size = sz;
        if (wr) begin
            ew.data = d; ew.strb = sel;
            q_aw.push_back(ea);
            q_w.push_back(ew);
            q_cmp.push_back(last_rd);
            exp_lat = 3 + ((daw > dw) ? daw : dw) + db;
        end else begin
            q_ar.push_back(ea);
            last_rd = rv;
            q_cmp.push_back(rv);
            exp_lat = 3 + dar + dr;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc == 1) begin
                // request already accepted: wiggle it to show it is ignored
                mem_a = $urandom; mem_st_data = $urandom; mem_sel = 4'($urandom);
                mem_size = 2'($urandom); mem_write = 1'($urandom);
            end
        end while (!mem_ready && cyc < 200);
        check("latency", 64'(cyc), 64'(exp_lat));
        @(negedge clk);
        mem_access = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_t ea;
        int    cyc;
        logic  wr;
        logic [1:0] rr;
        resetn = 0; mem_access = 0; mem_write = 0; mem_a = 0; mem_size = 0;
        mem_sel = 0; mem_st_data = 0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_valids", 64'({arvalid, rready, awvalid, wvalid, bready, mem_ready}), 64'd0);
        check("reset_mem_data", 64'(mem_data), 64'd0);
`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
        check("reset_err", 64'({bus_err, err_addr}), 64'd0);
`endif
        @(negedge clk);
        resetn = 1;

        // zero-wait read of the boot vector
        do_txn(1'b0, 32'hBFC00000, 2'd2, 4'hF, 32'h0, 32'h3C1D8000, 2'b00, 0, 0, 0, 0, 0);
        check("boot_read_data", 64'(mem_data), 64'h3C1D8000);

        // write with W accepted one cycle before AW
        do_txn(1'b1, 32'h80001004, 2'd2, 4'b0011, 32'h0000BEEF, 32'h0, 2'b00, 0, 0, 1, 0, 0);
        check("write_keeps_mem_data", 64'(mem_data), 64'h3C1D8000);

        // read under AR and R backpressure
        do_txn(1'b0, 32'h00002000, 2'd2, 4'h0, 32'h0, 32'h12345678, 2'b00, 5, 3, 0, 0, 0);

        // reset asserted while waiting in RD_DATA
        ar_dly = 0; r_dly = 60; rd_val = 32'hDEAD0001; rd_resp = 2'b00;
        @(negedge clk);
        mem_access = 1; mem_write = 0; mem_a = 32'h00001230; mem_size = 2'd2;
        ea.addr = 32'h00001230; ea.size = 2'd2;
        q_ar.push_back(ea);
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
        end while (!rready && cyc < 20);
        check("rst_reached_rd_data", 64'(rready), 64'd1);
        #2;
        resetn = 0;
        #1;
        check("rst_mid_valids", 64'({arvalid, rready, awvalid, wvalid, bready, mem_ready}), 64'd0);
        check("rst_mid_mem_data", 64'(mem_data), 64'd0);
        mem_access = 0;
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1;
        do_txn(1'b0, 32'h00003000, 2'd1, 4'h0, 32'h0, 32'hCAFEF00D, 2'b00, 0, 0, 0, 0, 0);

        // randomized mix with random wait states
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
            rr = 2'b00;
`else
            rr = 2'($urandom);
`endif
            do_txn(wr, $urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom, rr,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef AXI_BRIDGE_ERR_CAPTURE_EN
        check("err_clear_after_okay", 64'(bus_err), 64'd0);
        do_txn(1'b0, 32'h1FAF0000, 2'd2, 4'h0, 32'h0, 32'h55AA55AA, 2'b10, 0, 1, 0, 0, 0);
        check("err_set", 64'(bus_err), 64'd1);
        check("err_addr", 64'(err_addr), 64'h1FAF0000);
        do_txn(1'b0, 32'h00004000, 2'd2, 4'h0, 32'h0, 32'h01020304, 2'b00, 0, 0, 0, 0, 0);
        check("err_sticky", 64'({bus_err, err_addr}), 64'({1'b1, 32'h1FAF0000}));
        do_txn(1'b1, 32'h00005000, 2'd2, 4'hF, 32'h11111111, 32'h0, 2'b11, 0, 0, 0, 0, 1);
        check("err_first_only", 64'({bus_err, err_addr}), 64'({1'b1, 32'h1FAF0000}));
`endif

        repeat (4) @(negedge clk);
        check("queues_drained", 64'(q_ar.size() + q_aw.size() + q_w.size() + q_cmp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Single-outstanding bridge between the shared cache memory port and the AXI3/4 master interface of the CPU top.
- Takes one read or write request at a time from the i_cache/d_cache mux and runs the AR/R or AW/W/B handshakes.
- Returns read data, or write completion, as a one-cycle mem_ready pulse.
- Sits directly downstream of the cache mux, at the CPU's external AXI boundary.

Parameters:
- AXI_ID, 4'b0000, value driven on arid/awid/wid.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- mem_a  in  32  request byte address
- mem_access  in  1  request valid, held by cache until mem_ready
- mem_write  in  1  1 = write, 0 = read
- mem_size  in  2  log2 bytes: 0 = byte, 1 = half, 2 = word
- mem_sel  in  4  write byte strobes
- mem_st_data  in  32  write data
- mem_data  out  32  read data
- mem_ready  out  1  one-cycle completion pulse
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AR channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1  AW channel
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready  in  1
- bid/bresp/bvalid  in  4/2/1; bready  out  1

Behaviour:
- Interface: one clock, clk; reset resetn is asynchronous, active-low.
- Constant outputs:
  - arid/awid/wid = AXI_ID; arlen = 0; awlen = 0; arburst/awburst = 2'b01; lock/cache/prot = 0; wlast = 1.
  - arsize = awsize = {1'b0, mem_size latched}.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset:
  - state = IDLE; all valid/ready outputs = 0; mem_data = 0; mem_ready = 0; latched addr/data/strobe = 0.
  - Reset asserted mid-transaction drops every valid at once, with no completion pulse.
- IDLE:
  - If mem_access = 1, latch mem_a, mem_size, mem_sel, mem_st_data and mem_write.
  - Go to RD_ADDR if mem_write = 0, otherwise WR_REQ.
  - No AXI output asserted in IDLE.
- RD_ADDR: arvalid = 1, araddr = latched addr. On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, latch rdata into mem_data and go to DONE.
  - rid, rlast and rresp are ignored (base build).
- WR_REQ:
  - awvalid and wvalid both asserted on entry.
  - Each is deasserted independently after its own handshake (awready / wready), tracked by aw_done/w_done flags.
  - When both handshakes have completed (same cycle or different cycles), go to WR_RESP.
  - wdata = latched data, wstrb = latched sel.
- WR_RESP: bready = 1. On bvalid, go to DONE.
- DONE:
  - mem_ready = 1 for exactly this cycle; then IDLE.
  - mem_access is not sampled in DONE. This guarantees the cache has one edge to drop mem_access, so no double issue.
- mem_data holds its value until the next read completes. Writes do not change it.
- Request inputs changing after acceptance have no effect.
- Best-case latency with a zero-wait slave: 4 cycles from mem_access seen in IDLE to the mem_ready pulse.
  - Read path: IDLE, RD_ADDR, RD_DATA, DONE.
  - Write path: IDLE, WR_REQ, WR_RESP, DONE.
- No combinational path from any AXI input to any AXI output.

Optional Feature:
- Macro: AXI_BRIDGE_ERR_CAPTURE_EN.
- Enabled:
  - Extra output bus_err (1 bit), sticky, reset 0.
  - Set when rresp[1] = 1 on an R handshake, or bresp[1] = 1 on a B handshake.
  - Extra output err_addr (32 bits), holding the latched address of the first erroring transaction.
  - Neither is cleared except by reset.
- Disabled: ports absent; rresp and bresp ignored.

Test Plan:
- Read, zero-wait slave: mem_a = 0xBFC00000, size 2 → araddr = 0xBFC00000, arsize = 3'b010, arlen = 0; slave returns rdata = 0x3C1D8000 → mem_ready pulse of 1 cycle, mem_data = 0x3C1D8000, 4 cycles after acceptance.
- Write with wready one cycle before awready: addr 0x80001004, sel 4'b0011, data 0x0000BEEF → wvalid drops first, awvalid drops later, then bresp → single mem_ready; wstrb = 4'b0011.
- Back-to-back: cache holds mem_access through DONE and drops it after mem_ready → exactly one AXI transaction issued.
- Backpressure: arready low for 5 cycles, rvalid delayed 3 cycles → araddr stable while arvalid is high; mem_ready only after the R handshake.
- Reset asserted during RD_DATA → arvalid/rready/mem_ready go to 0 immediately; after release, a new read completes normally.
- With AXI_BRIDGE_ERR_CAPTURE_EN: a read returning rresp = 2'b10 at addr 0x1FAF0000 → bus_err = 1 and err_addr = 0x1FAF0000; a later OKAY read leaves both unchanged.
